// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: load-use, load-to-branch and MDU-busy hazards,
// plus the MDU busy-window sequencer and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_RFR1,
  input  logic [4:0]       id_RFR2,
  input  logic             id_UseRs,
  input  logic             id_UseRt,
  input  logic             id_Branch,
  input  logic             id_MduUse,
  input  logic             exe_RegWrite,
  input  logic             exe_MemRead,
  input  logic [4:0]       exe_RegisterRd,
  input  logic             mem_MemRead,
  input  logic [4:0]       mem_RegisterRd,
  input  logic             exe_MulStart,
  input  logic             exe_DivStart,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXFlush,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cycles
);

  // state  | meaning
  // S_IDLE | no MDU operation in flight
  // S_BUSY | MDU computing; r_cnt counts remaining cycles down to 0
  localparam int MAX_C = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_ex_match, w_mem_match;
  logic w_load_use, w_br_load, w_mdu_haz, w_stall;
  logic w_unused;

  // ALU results are bypassed, so the EX write enable never contributes to a stall.
  assign w_unused = exe_RegWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (exe_DivStart) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CW'(DIV_CYCLES - 1);
        end else if (exe_MulStart) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CW'(MUL_CYCLES - 1);
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mdu_busy = (r_state == S_BUSY);
    mdu_done = (r_state == S_BUSY) && (r_cnt == '0);
  end

  assign w_ex_match  = (exe_RegisterRd != 5'd0) &&
                       ((id_UseRs && (exe_RegisterRd == id_RFR1)) ||
                        (id_UseRt && (exe_RegisterRd == id_RFR2)));
  assign w_mem_match = (mem_RegisterRd != 5'd0) &&
                       ((id_UseRs && (mem_RegisterRd == id_RFR1)) ||
                        (id_UseRt && (mem_RegisterRd == id_RFR2)));

  assign w_load_use = exe_MemRead && w_ex_match;
  assign w_br_load  = id_Branch && (w_load_use || (mem_MemRead && w_mem_match));
  assign w_mdu_haz  = mdu_busy && id_MduUse;
  assign w_stall    = !rst && (w_load_use || w_br_load || w_mdu_haz);

  always_comb begin
    PCWrite     = !w_stall;
    IFIDWrite   = !w_stall;
    IDEXFlush   = w_stall;
    stall_cause = 2'b00;
    if (!rst) begin
      if (w_mdu_haz)       stall_cause = 2'b11;
      else if (w_br_load)  stall_cause = 2'b10;
      else if (w_load_use) stall_cause = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}}))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table for single-cycle hazards,
// hand-written sequences for branch-after-load, MDU windows, saturation and reset.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_RFR1, id_RFR2;
  logic       id_UseRs, id_UseRt, id_Branch, id_MduUse;
  logic       exe_RegWrite, exe_MemRead;
  logic [4:0] exe_RegisterRd;
  logic       mem_MemRead;
  logic [4:0] mem_RegisterRd;
  logic       exe_MulStart, exe_DivStart;
  logic       PCWrite, IFIDWrite, IDEXFlush, mdu_busy, mdu_done;
  logic [1:0] stall_cause;
  logic [3:0] stall_cycles;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_cnt    = 4'd0;
  logic       allow_overlap = 1'b0;

  logic [10:0] exp_q[$];
  string       nm_q[$];

  typedef struct {
    string      nm;
    logic [4:0] rfr1, rfr2;
    logic       urs, urt, br, mduuse, exrw, exmr;
    logic [4:0] exrd;
    logic       memmr;
    logic [4:0] memrd;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[11];

  hazard_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_RFR1(id_RFR1), .id_RFR2(id_RFR2),
    .id_UseRs(id_UseRs), .id_UseRt(id_UseRt),
    .id_Branch(id_Branch), .id_MduUse(id_MduUse),
    .exe_RegWrite(exe_RegWrite), .exe_MemRead(exe_MemRead),
    .exe_RegisterRd(exe_RegisterRd),
    .mem_MemRead(mem_MemRead), .mem_RegisterRd(mem_RegisterRd),
    .exe_MulStart(exe_MulStart), .exe_DivStart(exe_DivStart),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .stall_cause(stall_cause), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Start pulses while the MDU is busy are a protocol violation except where deliberately injected.
  always @(negedge clk) begin
    if (!allow_overlap && !rst && mdu_busy && (exe_MulStart || exe_DivStart)) begin
      n_fail++;
      $display("FAIL protocol: start pulse while busy (busy=%b)", mdu_busy);
    end
  end

  task automatic clear_in();
    id_RFR1 = 5'd0; id_RFR2 = 5'd0; id_UseRs = 1'b0; id_UseRt = 1'b0;
    id_Branch = 1'b0; id_MduUse = 1'b0; exe_RegWrite = 1'b0; exe_MemRead = 1'b0;
    exe_RegisterRd = 5'd0; mem_MemRead = 1'b0; mem_RegisterRd = 5'd0;
    exe_MulStart = 1'b0; exe_DivStart = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    exe_MemRead = 1'b1; exe_RegWrite = 1'b1; exe_RegisterRd = r;
    id_RFR1 = r; id_UseRs = 1'b1;
  endtask

  // Expected {PCWrite,IFIDWrite,IDEXFlush,cause,busy,done,stall_cycles} for the current cycle.
  task automatic step(input string nm, input logic [1:0] c, input logic b, input logic d);
    logic        stall;
    logic [10:0] e, a;
    string       n;
    stall = (c != 2'b00);
    exp_q.push_back({~stall, ~stall, stall, c, b, d, m_cnt});
    nm_q.push_back(nm);
    @(negedge clk);
    a = {PCWrite, IFIDWrite, IDEXFlush, stall_cause, mdu_busy, mdu_done, stall_cycles};
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got pc/ifid/flush/cause/busy/done/cnt=%b, want %b", n, a, e);
    end
    if (rst)                         m_cnt = 4'd0;
    else if (stall && m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"lu_rs",       5'd5, 5'd0, 1,0,0,0,1,1, 5'd5, 0, 5'd0, 2'b01};
    vecs[1]  = '{"lu_no_urs",   5'd5, 5'd0, 0,0,0,0,1,1, 5'd5, 0, 5'd0, 2'b00};
    vecs[2]  = '{"lu_rd0",      5'd0, 5'd0, 1,0,0,0,1,1, 5'd0, 0, 5'd0, 2'b00};
    vecs[3]  = '{"lu_rt",       5'd0, 5'd7, 0,1,0,0,1,1, 5'd7, 0, 5'd0, 2'b01};
    vecs[4]  = '{"alu_ex",      5'd5, 5'd0, 1,0,0,0,1,0, 5'd5, 0, 5'd0, 2'b00};
    vecs[5]  = '{"br_ex_load",  5'd8, 5'd0, 1,0,1,0,1,1, 5'd8, 0, 5'd0, 2'b10};
    vecs[6]  = '{"br_mem_load", 5'd0, 5'd9, 0,1,1,0,0,0, 5'd0, 1, 5'd9, 2'b10};
    vecs[7]  = '{"nobr_mem_ld", 5'd0, 5'd9, 0,1,0,0,0,0, 5'd0, 1, 5'd9, 2'b00};
    vecs[8]  = '{"br_alu_ex",   5'd8, 5'd0, 1,0,1,0,1,0, 5'd8, 0, 5'd0, 2'b00};
    vecs[9]  = '{"mdu_idle",    5'd0, 5'd0, 0,0,0,1,0,0, 5'd0, 0, 5'd0, 2'b00};
    vecs[10] = '{"br_mem_rd0",  5'd0, 5'd0, 1,1,1,0,0,0, 5'd0, 1, 5'd0, 2'b00};

    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_load_use(5'd5);
    step("reset_hold", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    clear_in();
    step("idle", 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      clear_in();
      id_RFR1 = vecs[i].rfr1; id_RFR2 = vecs[i].rfr2;
      id_UseRs = vecs[i].urs; id_UseRt = vecs[i].urt;
      id_Branch = vecs[i].br; id_MduUse = vecs[i].mduuse;
      exe_RegWrite = vecs[i].exrw; exe_MemRead = vecs[i].exmr;
      exe_RegisterRd = vecs[i].exrd;
      mem_MemRead = vecs[i].memmr; mem_RegisterRd = vecs[i].memrd;
      step(vecs[i].nm, vecs[i].cause, 1'b0, 1'b0);
    end

    // beq $8 right after lw $8: EX match, then MEM match, then released
    clear_in();
    id_Branch = 1'b1; id_RFR1 = 5'd8; id_UseRs = 1'b1;
    exe_MemRead = 1'b1; exe_RegWrite = 1'b1; exe_RegisterRd = 5'd8;
    step("br_ld_c1", 2'b10, 1'b0, 1'b0);
    exe_MemRead = 1'b0; exe_RegWrite = 1'b0; exe_RegisterRd = 5'd0;
    mem_MemRead = 1'b1; mem_RegisterRd = 5'd8;
    step("br_ld_c2", 2'b10, 1'b0, 1'b0);
    mem_MemRead = 1'b0; mem_RegisterRd = 5'd0;
    step("br_ld_c3", 2'b00, 1'b0, 1'b0);
    // same shape with add $8: bypassed, no stall
    exe_RegWrite = 1'b1; exe_RegisterRd = 5'd8;
    step("br_add_c1", 2'b00, 1'b0, 1'b0);
    exe_RegWrite = 1'b0; exe_RegisterRd = 5'd0; mem_RegisterRd = 5'd8;
    step("br_add_c2", 2'b00, 1'b0, 1'b0);

    // multiply with mflo held in ID
    clear_in();
    id_MduUse = 1'b1; exe_MulStart = 1'b1;
    step("mul_t", 2'b00, 1'b0, 1'b0);
    exe_MulStart = 1'b0;
    step("mul_t1", 2'b11, 1'b1, 1'b0);
    set_load_use(5'd5);
    step("mul_t2_prio", 2'b11, 1'b1, 1'b0);
    exe_MemRead = 1'b0; exe_RegWrite = 1'b0; exe_RegisterRd = 5'd0;
    step("mul_t3", 2'b11, 1'b1, 1'b0);
    step("mul_t4_done", 2'b11, 1'b1, 1'b1);
    step("mul_t5", 2'b00, 1'b0, 1'b0);

    // divide and multiply together: divide wins; a mid-window start is ignored
    clear_in();
    exe_DivStart = 1'b1; exe_MulStart = 1'b1;
    step("div_start", 2'b00, 1'b0, 1'b0);
    clear_in();
    allow_overlap = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      exe_MulStart = (i == 5);
      exe_DivStart = (i == 30);
      step($sformatf("div_busy_%0d", i), 2'b00, 1'b1, (i == 32));
    end
    clear_in();
    allow_overlap = 1'b0;
    step("div_end", 2'b00, 1'b0, 1'b0);

    // counter saturation from a fresh reset
    rst = 1'b1;
    step("rst_pre_sat", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    set_load_use(5'd3);
    for (int i = 0; i < 20; i++) step($sformatf("sat_%0d", i), 2'b01, 1'b0, 1'b0);
    clear_in();
    step("sat_final", 2'b00, 1'b0, 1'b0);

    // reset in the 10th divide busy cycle, with a load-use match present
    exe_DivStart = 1'b1;
    step("rdiv_start", 2'b00, 1'b0, 1'b0);
    clear_in();
    for (int i = 1; i <= 9; i++) step($sformatf("rdiv_busy_%0d", i), 2'b00, 1'b1, 1'b0);
    rst = 1'b1;
    set_load_use(5'd6);
    step("rdiv_rst", 2'b00, 1'b1, 1'b0);
    rst = 1'b0;
    clear_in();
    step("rdiv_after", 2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
